if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 162 ++++++++++++++++
 tb/tb_if_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch unit: PC, one-read-per-cycle issue, decode FIFO, redirect and HALT.
// Optional FETCH_PERF_EN adds saturating delivered-instruction and stall counters.
module if_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          BUF_DEPTH   = 2,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  input  logic [15:0] im_instr,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_instr_cnt,
  output logic [15:0] perf_stall_cnt
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   buf_instr_q [BUF_DEPTH];
  logic [15:0]   buf_instr_d [BUF_DEPTH];
  logic [15:0]   buf_pc_q    [BUF_DEPTH];
  logic [15:0]   buf_pc_d    [BUF_DEPTH];
  logic [15:0]   last_instr_q, last_instr_d;
  logic [15:0]   last_pc_q, last_pc_d;

  logic pop;
  logic push;

  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && dec_ready;
  assign im_rd_en  = (state_q == S_RUN) && !redirect && ((count_q < DEPTH_C) || pop);
  assign push      = im_rd_en;
  assign im_addr   = pc_q;
  assign halted    = (state_q == S_HALTED);

  // When empty, the outputs keep showing the last word that left the FIFO.
  assign dec_instr = dec_valid ? buf_instr_q[rd_ptr_q] : last_instr_q;
  assign dec_pc    = dec_valid ? buf_pc_q[rd_ptr_q]    : last_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;

    if (redirect) begin
      // Flush wins over any pop, capture or HALT in the same cycle.
      state_d  = S_RUN;
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_RUN;
        S_RUN:    if (push && (im_instr[15:12] == HALT_OPCODE)) state_d = S_HALTED;
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_IDLE;
      endcase

      if (push) begin
        buf_instr_d[wr_ptr_q] = im_instr;
        buf_pc_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = wr_ptr_q + 1'b1;
        pc_d                  = pc_q + 16'd1;
      end

      if (pop) begin
        last_instr_d = buf_instr_q[rd_ptr_q];
        last_pc_d    = buf_pc_q[rd_ptr_q];
        rd_ptr_d     = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_instr_q <= '0;
      last_pc_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_instr_q, perf_instr_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_stall_d = perf_stall_q;
    if (pop && (perf_instr_q != 16'hFFFF)) perf_instr_d = perf_instr_q + 16'd1;
    if ((state_q == S_RUN) && !im_rd_en && !redirect && (perf_stall_q != 16'hFFFF))
      perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_instr_cnt = perf_instr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch: streaming, stall, redirect, HALT, PC wrap, async reset.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] im_addr, im_instr;
  logic        im_rd_en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [15:0] dec_instr, dec_pc;
  logic        halted;

  logic [15:0] w_im_addr, w_im_instr, w_dec_instr, w_dec_pc;
  logic        w_im_rd_en, w_dec_valid, w_halted;

  int n_checks = 0;
  int n_fail   = 0;
  int w_idx    = 0;
  logic [31:0] sb_q[$];

  localparam logic [15:0] HALT_AT = 16'h0043;
  logic [15:0] w_pc_exp    [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] w_instr_exp [4] = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001};

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_rd_en(im_rd_en), .im_instr(im_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc), .halted(halted)
  );

  if_fetch #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst), .im_addr(w_im_addr), .im_rd_en(w_im_rd_en), .im_instr(w_im_instr),
    .redirect(1'b0), .redirect_pc(16'h0000), .dec_valid(w_dec_valid),
    .dec_ready(1'b1), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .halted(w_halted)
  );

  function automatic logic [15:0] mem_base(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  function automatic logic [15:0] mem_main(input logic [15:0] a);
    return (a == HALT_AT) ? 16'hF000 : mem_base(a);
  endfunction

  // Memory latches on clk low.
  always @(negedge clk) begin
    im_instr   <= mem_main(im_addr);
    w_im_instr <= mem_base(w_im_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_range(input logic [15:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] p;
      p = pc0 + 16'(i);
      sb_q.push_back({mem_main(p), p});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"},  {31'd0, im_rd_en},  32'd0);
    chk({tag, "_valid"},  {31'd0, dec_valid}, 32'd0);
    chk({tag, "_instr"},  {16'd0, dec_instr}, 32'd0);
    chk({tag, "_pc"},     {16'd0, dec_pc},    32'd0);
    chk({tag, "_halted"}, {31'd0, halted},    32'd0);
    chk({tag, "_addr"},   {16'd0, im_addr},   32'd0);
  endtask

  // Scoreboard monitor: every accepted head word must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pop", {16'd0, dec_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("dec_instr", {16'd0, dec_instr}, {16'd0, e[31:16]});
        chk("dec_pc",    {16'd0, dec_pc},    {16'd0, e[15:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_dec_valid && (w_idx < 4)) begin
      chk("wrap_pc",    {16'd0, w_dec_pc},    {16'd0, w_pc_exp[w_idx]});
      chk("wrap_instr", {16'd0, w_dec_instr}, {16'd0, w_instr_exp[w_idx]});
      w_idx++;
    end
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; dec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    push_range(16'h0000, 14);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rd_en", {31'd0, im_rd_en}, 32'd0);
    @(negedge clk);
    chk("first_rd_en", {31'd0, im_rd_en}, 32'd1);
    chk("first_addr",  {16'd0, im_addr},  32'h0000);

    repeat (11) @(posedge clk);
    #1 dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", {31'd0, dec_valid}, 32'd1);
      chk("stall_instr", {16'd0, dec_instr}, 32'h100A);
      chk("stall_pc",    {16'd0, dec_pc},    32'h000A);
      chk("stall_rd_en", {31'd0, im_rd_en},  32'd0);
    end
    @(posedge clk);
    #1 dec_ready = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    dec_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    push_range(16'h0040, 4);
    @(negedge clk);
    chk("redir_rd_en", {31'd0, im_rd_en},  32'd0);
    chk("redir_full",  {16'd0, dec_instr}, 32'h100E);
    @(posedge clk);
    #1;
    redirect = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'd0, dec_valid}, 32'd0);
    chk("refetch_en",  {31'd0, im_rd_en},  32'd1);
    chk("refetch_adr", {16'd0, im_addr},   32'h0040);

    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("halted",      {31'd0, halted},    32'd1);
    chk("halt_rd_en",  {31'd0, im_rd_en},  32'd0);
    chk("halt_empty",  {31'd0, dec_valid}, 32'd0);
    chk("halt_hold_i", {16'd0, dec_instr}, 32'hF000);
    chk("halt_hold_p", {16'd0, dec_pc},    32'h0043);

    @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 16'h0010;
    push_range(16'h0010, 4);
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    chk("unhalt",      {31'd0, halted},   32'd0);
    chk("resume_en",   {31'd0, im_rd_en}, 32'd1);
    chk("resume_addr", {16'd0, im_addr},  32'h0010);

    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    push_range(16'h0000, 4);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 dec_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained",  sb_q.size(), 32'd0);
    chk("wrap_seen",   w_idx,       32'd4);
    chk("final_valid", {31'd0, dec_valid}, 32'd1);
    chk("final_pc",    {16'd0, dec_pc},    32'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
